ram_burst_master: RTL and testbench

- Burst access engine that drives the 4096 x 16 RAM block's port set (`sel`, `in`, `load`, `out`) on behalf of a command stream.
- Accepts one write or read burst command at a time with a start address and a word count.
- Write data arrives, and read data leaves, on valid/ready streams with full backpressure.
- Sits between the CPU/DMA side and the RAM, and is the only driver of the RAM ports.

---
 rtl/ram_burst_master.sv | 136 +++++++++++++
 tb/tb_ram_burst_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// ram_burst_master: burst engine that owns the RAM port set (sel/in/load/out)
// and moves whole write or read bursts between the RAM and two word streams.
//
// Handshake rule for every stream here (cmd, wr, rd): a transfer happens on a
// rising edge where valid and ready are both 1; valid, once raised by the
// source, is not required to be held, and ready may depend combinationally on
// state only (never on the partner's valid).
module ram_burst_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] mem_sel,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;

    // State, burst pointer/count and the read output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next-state, burst bookkeeping and stream ready signals.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;

        // A consumed word leaves the output register unless a capture below
        // refills it in the same cycle.
        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    state_d = cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                // Capture whenever the output register is empty or being drained.
                if (!rd_valid_q || rd_ready) begin
                    rd_data_d  = mem_out;
                    rd_valid_d = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    if (rem_q == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (rd_valid_q && rd_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM port drive: address follows the burst pointer; writes are same-cycle
    // and suppressed whenever reset is asserted.
    assign mem_sel  = addr_q;
    assign mem_in   = wr_data;
    assign mem_load = (state_q == ST_WRITE) && wr_valid && !rst;

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: behavioural 4096x16 RAM, cycle table for the
// basic write/read bursts, hand sequences for backpressure, wrap, reset and
// ignored inputs, and a whole-memory comparison against an expected image.
module tb_ram_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr, cmd_len;
    logic [15:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid, rd_ready;
    logic [11:0] mem_sel;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;
    logic        busy, done;

    logic [15:0] ram     [4096];
    logic [15:0] exp_mem [4096];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;

    // clock / reset block
    always #5 clk = ~clk;

    ram_burst_master #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .mem_sel(mem_sel), .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out),
        .busy(busy), .done(done)
    );

    // RAM model: combinational read, clocked write
    assign mem_out = ram[mem_sel];
    always @(posedge clk) begin
        if (mem_load) ram[mem_sel] <= mem_in;
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic        cv; logic cw; logic [11:0] ca; logic [11:0] cl;
        logic        wv; logic [15:0] wd; logic rr;
        logic        e_crdy; logic e_busy; logic e_done; logic e_load; logic e_wrdy;
        logic        chk_sel; logic [11:0] e_sel;
        logic        e_rv; logic [15:0] e_rd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;
    endtask

    // Write burst with wr_valid held high; data d0, d0+1, ...
    task automatic run_write(input logic [11:0] a, input logic [11:0] l, input logic [15:0] d0);
        logic [11:0] s;
        cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_len = l; wr_valid = 0;
        #1 chk("wr_cmd_ready", cmd_ready, 1);
        next_cycle();
        cmd_valid = 0;
        for (int i = 0; i <= int'(l); i++) begin
            s = a + 12'(i);
            wr_valid = 1; wr_data = d0 + 16'(i);
            #1;
            chk("wr_load", mem_load, 1);
            chk("wr_sel", mem_sel, s);
            exp_mem[s] = wr_data;
            next_cycle();
        end
        wr_valid = 0;
        #1 chk("wr_done", done, 1);
        next_cycle();
    endtask

    // Read burst; exp_q must hold the expected words. pat gives rd_ready for the
    // first 7 cycles after the command, then 1. stray drives wr_valid and a
    // competing write command while the burst runs.
    task automatic run_read(input logic [11:0] a, input logic [11:0] l,
                            input logic [6:0] pat, input logic stray);
        logic [15:0] held;
        logic        held_valid;
        logic        seen;
        logic [15:0] w;
        held_valid = 0; seen = 0; held = '0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_len = l; rd_ready = 0;
        #1 chk("rd_cmd_ready", cmd_ready, 1);
        next_cycle();
        cmd_valid = 0;
        if (stray) begin
            cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h300; cmd_len = 12'h000;
            wr_valid = 1; wr_data = 16'h7777;
        end
        for (int k = 0; k < 40 && !seen; k++) begin
            rd_ready = (k < 7) ? pat[k] : 1'b1;
            #1;
            if (stray) begin
                chk("stray_cmd_ready", cmd_ready, 0);
                chk("stray_wr_ready", wr_ready, 0);
                chk("stray_load", mem_load, 0);
            end
            if (rd_valid) begin
                if (held_valid) chk("rd_hold", rd_data, held);
                if (rd_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rd_extra_word", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        chk("rd_word", rd_data, w);
                    end
                    held_valid = 0;
                end else begin
                    held = rd_data;
                    held_valid = 1;
                end
            end else begin
                held_valid = 0;
            end
            if (done) seen = 1;
            next_cycle();
        end
        rd_ready = 0;
        chk("rd_done_seen", seen, 1);
        chk("rd_all_words", exp_q.size(), 0);
    endtask

    int          base_done;
    int          mism;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 16'(i) ^ 16'h5A5A;
            exp_mem[i] = 16'(i) ^ 16'h5A5A;
        end

        //            cv cw ca      cl     wv wd        rr crdy busy done load wrdy chks sel     rv rd
        vecs[0]  = '{1, 1, 12'h010, 12'd3, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 12'h000, 0, 16'h0000};
        vecs[1]  = '{0, 0, 12'h000, 12'd0, 1, 16'h1111, 0, 0, 1, 0, 1, 1, 1, 12'h010, 0, 16'h0000};
        vecs[2]  = '{0, 0, 12'h000, 12'd0, 1, 16'h2222, 0, 0, 1, 0, 1, 1, 1, 12'h011, 0, 16'h0000};
        vecs[3]  = '{0, 0, 12'h000, 12'd0, 1, 16'h3333, 0, 0, 1, 0, 1, 1, 1, 12'h012, 0, 16'h0000};
        vecs[4]  = '{0, 0, 12'h000, 12'd0, 1, 16'h4444, 0, 0, 1, 0, 1, 1, 1, 12'h013, 0, 16'h0000};
        vecs[5]  = '{0, 0, 12'h000, 12'd0, 0, 16'h0000, 0, 0, 1, 1, 0, 0, 0, 12'h000, 0, 16'h0000};
        vecs[6]  = '{1, 0, 12'h010, 12'd3, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 12'h000, 0, 16'h0000};
        vecs[7]  = '{0, 0, 12'h000, 12'd0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 1, 12'h010, 0, 16'h0000};
        vecs[8]  = '{0, 0, 12'h000, 12'd0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 1, 12'h011, 1, 16'h1111};
        vecs[9]  = '{0, 0, 12'h000, 12'd0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 1, 12'h012, 1, 16'h2222};
        vecs[10] = '{0, 0, 12'h000, 12'd0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 1, 12'h013, 1, 16'h3333};
        vecs[11] = '{0, 0, 12'h000, 12'd0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 12'h000, 1, 16'h4444};
        vecs[12] = '{0, 0, 12'h000, 12'd0, 0, 16'h0000, 1, 0, 1, 1, 0, 0, 0, 12'h000, 0, 16'h0000};
        vecs[13] = '{0, 0, 12'h000, 12'd0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 12'h000, 0, 16'h0000};

        // reset
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 chk("rst_load", mem_load, 0);
        rst = 0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_wr_ready", wr_ready, 0);

        // table: write 4 words at 0x010, then read them back
        for (int i = 0; i < 14; i++) begin
            cmd_valid = vecs[i].cv; cmd_write = vecs[i].cw;
            cmd_addr  = vecs[i].ca; cmd_len   = vecs[i].cl;
            wr_valid  = vecs[i].wv; wr_data   = vecs[i].wd;
            rd_ready  = vecs[i].rr;
            #1;
            chk($sformatf("v%0d_cmd_ready", i), cmd_ready, vecs[i].e_crdy);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
            chk($sformatf("v%0d_load", i), mem_load, vecs[i].e_load);
            chk($sformatf("v%0d_wr_ready", i), wr_ready, vecs[i].e_wrdy);
            chk($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].e_rv);
            if (vecs[i].chk_sel) chk($sformatf("v%0d_sel", i), mem_sel, vecs[i].e_sel);
            if (vecs[i].e_rv) chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].e_rd);
            next_cycle();
        end
        exp_mem[12'h010] = 16'h1111; exp_mem[12'h011] = 16'h2222;
        exp_mem[12'h012] = 16'h3333; exp_mem[12'h013] = 16'h4444;
        idle_inputs();

        // backpressured read: rd_ready 1,0,0,1,1,0,1
        exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        base_done = done_cnt;
        run_read(12'h010, 12'd3, 7'b1011001, 1'b0);
        chk("bp_done_once", done_cnt - base_done, 1);
        idle_inputs();

        // address wrap: 3 words at 0xFFE
        run_write(12'hFFE, 12'd2, 16'hA001);
        chk("wrap_ram_000", ram[12'h000], 16'hA003);
        exp_q = '{exp_mem[12'hFFE], exp_mem[12'hFFF], exp_mem[12'h000]};
        run_read(12'hFFE, 12'd2, 7'b1111111, 1'b0);
        idle_inputs();

        // reset after 2 of 5 words
        base_done = done_cnt;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h100; cmd_len = 12'd4;
        next_cycle();
        cmd_valid = 0;
        wr_valid = 1; wr_data = 16'hB001; exp_mem[12'h100] = 16'hB001;
        next_cycle();
        wr_data = 16'hB002; exp_mem[12'h101] = 16'hB002;
        next_cycle();
        wr_data = 16'hB003; rst = 1;
        #1 chk("midrst_load", mem_load, 0);
        next_cycle();
        rst = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_wr_ready", wr_ready, 0);
        chk("midrst_load_after", mem_load, 0);
        wr_valid = 0;
        next_cycle();
        chk("midrst_no_done", done_cnt - base_done, 0);
        chk("midrst_ram_102", ram[12'h102], exp_mem[12'h102]);

        // ignored inputs during a read, then the held command is taken after done
        exp_q = '{exp_mem[12'h200], exp_mem[12'h201]};
        run_read(12'h200, 12'd1, 7'b1111111, 1'b1);
        #1 chk("queued_cmd_ready", cmd_ready, 1);
        next_cycle();
        #1;
        chk("queued_wr_load", mem_load, 1);
        chk("queued_wr_sel", mem_sel, 12'h300);
        exp_mem[12'h300] = 16'h7777;
        next_cycle();
        wr_valid = 0; cmd_valid = 0;
        #1 chk("queued_done", done, 1);
        next_cycle();
        idle_inputs();

        // whole-memory image
        mism = 0;
        for (int i = 0; i < 4096; i++) begin
            if (ram[i] !== exp_mem[i]) mism++;
        end
        chk("ram_image_mismatches", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
